// File: rtl/load_store_unit_if.sv
// Core-request, memory-request/response and completion signals of the
// load/store unit, bundled so the LSU and its environment share one port.
interface load_store_unit_if #(
    parameter int XLEN = 32
);
    localparam int STRB_W = XLEN / 8;

    logic              i_Valid_1;
    logic              o_Ready_1;
    logic              i_Load_1;
    logic              i_Store_1;
    logic              i_LoadUnsigned_1;
    logic [1:0]        i_LoadStoreWidth_2;
    logic [XLEN-1:0]   i_Addr_XLEN;
    logic [XLEN-1:0]   i_StoreData_XLEN;
    logic              o_MemReqValid_1;
    logic              i_MemReqReady_1;
    logic [XLEN-1:0]   o_MemAddr_XLEN;
    logic              o_MemWrite_1;
    logic [XLEN-1:0]   o_MemWData_XLEN;
    logic [STRB_W-1:0] o_MemStrb;
    logic              i_MemRspValid_1;
    logic [XLEN-1:0]   i_MemRData_XLEN;
    logic              i_MemRspErr_1;
    logic              o_Done_1;
    logic [XLEN-1:0]   o_LoadData_XLEN;
    logic              o_Misaligned_1;
    logic              o_BusErr_1;
    logic              o_Busy_1;

    // LSU side
    modport slave (
        input  i_Valid_1, i_Load_1, i_Store_1, i_LoadUnsigned_1, i_LoadStoreWidth_2,
        input  i_Addr_XLEN, i_StoreData_XLEN, i_MemReqReady_1,
        input  i_MemRspValid_1, i_MemRData_XLEN, i_MemRspErr_1,
        output o_Ready_1, o_MemReqValid_1, o_MemAddr_XLEN, o_MemWrite_1,
        output o_MemWData_XLEN, o_MemStrb, o_Done_1, o_LoadData_XLEN,
        output o_Misaligned_1, o_BusErr_1, o_Busy_1
    );

    // Core plus memory side (the environment driving the LSU)
    modport master (
        output i_Valid_1, i_Load_1, i_Store_1, i_LoadUnsigned_1, i_LoadStoreWidth_2,
        output i_Addr_XLEN, i_StoreData_XLEN, i_MemReqReady_1,
        output i_MemRspValid_1, i_MemRData_XLEN, i_MemRspErr_1,
        input  o_Ready_1, o_MemReqValid_1, o_MemAddr_XLEN, o_MemWrite_1,
        input  o_MemWData_XLEN, o_MemStrb, o_Done_1, o_LoadData_XLEN,
        input  o_Misaligned_1, o_BusErr_1, o_Busy_1
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: latches one core request, checks
// alignment, issues one memory transaction with lane strobes and replicated
// store data, then extracts/extends the load result and reports completion.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input logic               i_Clk_1,
    input logic               i_Rstn_1,
    load_store_unit_if.slave  bus
);
    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic              write_q, write_d;
    logic              zext_q, zext_d;
    logic [1:0]        width_q, width_d;
    logic              done_q, done_d;
    logic              mis_q, mis_d;
    logic              berr_q, berr_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;

    // Doubleword on a 32-bit unit, or an address not a multiple of the size.
    function automatic logic misaligned(input logic [2:0] a, input logic [1:0] width);
        logic [2:0] amask;
        amask = 3'((4'd1 << width) - 4'd1);
        return ((width == 2'b11) && (XLEN == 32)) || (|(a & amask));
    endfunction

    // Contiguous byte enables starting at the address lane.
    function automatic logic [STRB_W-1:0] lane_strobe(input logic [OFF_W-1:0] off,
                                                       input logic [1:0] width);
        logic [STRB_W-1:0] r;
        int lo, hi;
        lo = int'(off);
        hi = lo + (1 << width);
        for (int i = 0; i < STRB_W; i++) r[i] = (i >= lo) && (i < hi);
        return r;
    endfunction

    // Store datum of the access size repeated across every byte lane.
    function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] data,
                                                   input logic [1:0] width);
        logic [XLEN-1:0] r;
        int sz;
        sz = 1 << width;
        for (int i = 0; i < STRB_W; i++) r[i*8 +: 8] = data[(i & (sz - 1))*8 +: 8];
        return r;
    endfunction

    // Shift the addressed lane down, keep size bytes, sign- or zero-extend.
    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] rdata,
                                                 input logic [OFF_W-1:0] off,
                                                 input logic [1:0] width,
                                                 input logic zext);
        logic [XLEN-1:0] sh, mask, r;
        int nb;
        sh = rdata >> {off, 3'b000};
        nb = 8 << width;
        if (nb > XLEN) nb = XLEN;
        for (int i = 0; i < XLEN; i++) mask[i] = (i < nb);
        r = sh & mask;
        if (!zext && sh[nb-1]) r = r | ~mask;
        return r;
    endfunction

    // Next-state and next-output computation for the request FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        write_d     = write_q;
        zext_d      = zext_q;
        width_d     = width_q;
        done_d      = 1'b0;
        mis_d       = mis_q;
        berr_d      = berr_q;
        load_data_d = load_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_Valid_1 && (bus.i_Load_1 || bus.i_Store_1)) begin
                    addr_d  = bus.i_Addr_XLEN;
                    write_d = bus.i_Store_1 && !bus.i_Load_1;
                    zext_d  = bus.i_LoadUnsigned_1;
                    width_d = bus.i_LoadStoreWidth_2;
                    wdata_d = replicate(bus.i_StoreData_XLEN, bus.i_LoadStoreWidth_2);
                    strb_d  = lane_strobe(bus.i_Addr_XLEN[OFF_W-1:0], bus.i_LoadStoreWidth_2);
                    if (misaligned(bus.i_Addr_XLEN[2:0], bus.i_LoadStoreWidth_2)) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        mis_d       = 1'b1;
                        berr_d      = 1'b0;
                        load_data_d = '0;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.i_MemReqReady_1) state_d = S_RSP;
            end
            S_RSP: begin
                if (bus.i_MemRspValid_1) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    mis_d       = 1'b0;
                    berr_d      = bus.i_MemRspErr_1;
                    load_data_d = (bus.i_MemRspErr_1 || write_q) ? '0 :
                                  extract(bus.i_MemRData_XLEN, addr_q[OFF_W-1:0], width_q, zext_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset drops any transaction in flight.
    always_ff @(posedge i_Clk_1 or negedge i_Rstn_1) begin
        if (!i_Rstn_1) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            write_q     <= 1'b0;
            zext_q      <= 1'b0;
            width_q     <= 2'b00;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            berr_q      <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            write_q     <= write_d;
            zext_q      <= zext_d;
            width_q     <= width_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
            berr_q      <= berr_d;
            load_data_q <= load_data_d;
        end
    end

    assign bus.o_Ready_1       = (state_q == S_IDLE);
    assign bus.o_Busy_1        = (state_q != S_IDLE);
    assign bus.o_MemReqValid_1 = (state_q == S_REQ);
    assign bus.o_MemAddr_XLEN  = addr_q;
    assign bus.o_MemWrite_1    = write_q;
    assign bus.o_MemWData_XLEN = wdata_q;
    assign bus.o_MemStrb       = strb_q;
    assign bus.o_Done_1        = done_q;
    assign bus.o_LoadData_XLEN = load_data_q;
    assign bus.o_Misaligned_1  = mis_q;
    assign bus.o_BusErr_1      = berr_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: one 32-bit and one 64-bit instance, a memory
// responder per instance and a completion scoreboard shared by both.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_store_unit_if #(.XLEN(32)) if32 ();
    load_store_unit_if #(.XLEN(64)) if64 ();

    load_store_unit #(.XLEN(32)) dut32 (.i_Clk_1(clk), .i_Rstn_1(rst_n), .bus(if32));
    load_store_unit #(.XLEN(64)) dut64 (.i_Clk_1(clk), .i_Rstn_1(rst_n), .bus(if64));

    // Bench-side view, index 0 = 32-bit unit, 1 = 64-bit unit.
    logic        valid [2];
    logic        ld    [2];
    logic        st    [2];
    logic        uns   [2];
    logic [1:0]  wid   [2];
    logic [63:0] addr  [2];
    logic [63:0] sdata [2];
    logic        mrdy  [2];
    logic        mrv   [2];
    logic [63:0] mrdata[2];
    logic        merr  [2];
    logic        rdy   [2];
    logic        mreqv [2];
    logic        mwr   [2];
    logic        dn    [2];
    logic        mis   [2];
    logic        berr  [2];
    logic        busy  [2];
    logic [63:0] maddr [2];
    logic [63:0] mwdata[2];
    logic [63:0] ldata [2];
    logic [7:0]  mstrb [2];

    assign if32.i_Valid_1          = valid[0];
    assign if32.i_Load_1           = ld[0];
    assign if32.i_Store_1          = st[0];
    assign if32.i_LoadUnsigned_1   = uns[0];
    assign if32.i_LoadStoreWidth_2 = wid[0];
    assign if32.i_Addr_XLEN        = addr[0][31:0];
    assign if32.i_StoreData_XLEN   = sdata[0][31:0];
    assign if32.i_MemReqReady_1    = mrdy[0];
    assign if32.i_MemRspValid_1    = mrv[0];
    assign if32.i_MemRData_XLEN    = mrdata[0][31:0];
    assign if32.i_MemRspErr_1      = merr[0];
    assign rdy[0]    = if32.o_Ready_1;
    assign mreqv[0]  = if32.o_MemReqValid_1;
    assign mwr[0]    = if32.o_MemWrite_1;
    assign dn[0]     = if32.o_Done_1;
    assign mis[0]    = if32.o_Misaligned_1;
    assign berr[0]   = if32.o_BusErr_1;
    assign busy[0]   = if32.o_Busy_1;
    assign maddr[0]  = {32'h0, if32.o_MemAddr_XLEN};
    assign mwdata[0] = {32'h0, if32.o_MemWData_XLEN};
    assign ldata[0]  = {32'h0, if32.o_LoadData_XLEN};
    assign mstrb[0]  = {4'h0, if32.o_MemStrb};

    assign if64.i_Valid_1          = valid[1];
    assign if64.i_Load_1           = ld[1];
    assign if64.i_Store_1          = st[1];
    assign if64.i_LoadUnsigned_1   = uns[1];
    assign if64.i_LoadStoreWidth_2 = wid[1];
    assign if64.i_Addr_XLEN        = addr[1];
    assign if64.i_StoreData_XLEN   = sdata[1];
    assign if64.i_MemReqReady_1    = mrdy[1];
    assign if64.i_MemRspValid_1    = mrv[1];
    assign if64.i_MemRData_XLEN    = mrdata[1];
    assign if64.i_MemRspErr_1      = merr[1];
    assign rdy[1]    = if64.o_Ready_1;
    assign mreqv[1]  = if64.o_MemReqValid_1;
    assign mwr[1]    = if64.o_MemWrite_1;
    assign dn[1]     = if64.o_Done_1;
    assign mis[1]    = if64.o_Misaligned_1;
    assign berr[1]   = if64.o_BusErr_1;
    assign busy[1]   = if64.o_Busy_1;
    assign maddr[1]  = if64.o_MemAddr_XLEN;
    assign mwdata[1] = if64.o_MemWData_XLEN;
    assign ldata[1]  = if64.o_LoadData_XLEN;
    assign mstrb[1]  = if64.o_MemStrb;

    typedef struct {
        logic [63:0] ldata;
        logic        mis;
        logic        berr;
        int          cyc;
    } cmp_t;

    typedef struct {
        logic [63:0] addr;
        logic        wr;
        logic [7:0]  strb;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        int          wait_n;
        logic        late;
    } req_t;

    cmp_t sbq[$];
    req_t rq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    logic late_next = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory responder and completion monitor per instance.
    for (genvar g = 0; g < 2; g++) begin : g_env
        cmp_t c;

        initial begin
            req_t r;
            mrdy[g] = 1'b0; mrv[g] = 1'b0; mrdata[g] = '0; merr[g] = 1'b0;
            forever begin
                @(negedge clk);
                if (rst_n && mreqv[g]) begin
                    if (rq.size() == 0) begin
                        chk("unexpected_req", 64'(mreqv[g]), 64'd0);
                    end else begin
                        r = rq.pop_front();
                        for (int i = 0; i <= r.wait_n; i++) begin
                            chk("req_valid", 64'(mreqv[g]), 64'd1);
                            chk("req_addr", maddr[g], r.addr);
                            chk("req_write", 64'(mwr[g]), 64'(r.wr));
                            chk("req_strb", 64'(mstrb[g]), 64'(r.strb));
                            chk("req_wdata", mwdata[g], r.wdata);
                            if (i < r.wait_n) @(negedge clk);
                        end
                        mrdy[g] = 1'b1;
                        @(negedge clk);
                        mrdy[g] = 1'b0;
                        if (r.late) begin
                            for (int k = 0; k < 40 && rst_n; k++) @(negedge clk);
                            for (int k = 0; k < 40 && !rst_n; k++) @(negedge clk);
                        end
                        mrv[g] = 1'b1; mrdata[g] = r.rdata; merr[g] = r.err;
                        @(negedge clk);
                        mrv[g] = 1'b0; merr[g] = 1'b0;
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (dn[g]) begin
                if (sbq.size() == 0) begin
                    chk("spurious_done", 64'(dn[g]), 64'd0);
                end else begin
                    c = sbq.pop_front();
                    chk("done_ldata", ldata[g], c.ldata);
                    chk("done_mis", 64'(mis[g]), 64'(c.mis));
                    chk("done_berr", 64'(berr[g]), 64'(c.berr));
                    chk("done_cycle", 64'(cyc), 64'(c.cyc));
                end
            end
        end
    end

    // Called at a falling edge; returns at a falling edge with the unit ready.
    task automatic wait_ready(input int d);
        int k;
        for (k = 0; k < 80 && !rdy[d]; k++) @(negedge clk);
        if (k == 80) chk("ready_timeout", 64'(rdy[d]), 64'd1);
    endtask

    task automatic wait_idle(input int d);
        int k;
        for (k = 0; k < 80; k++) begin
            @(negedge clk);
            if (sbq.size() == 0 && rq.size() == 0 && rdy[d]) break;
        end
        if (k == 80) chk("idle_timeout", 64'(sbq.size()), 64'd0);
    endtask

    // Drive one request and push its expected request payload and completion.
    task automatic issue(input int d, input logic l, input logic s, input logic u,
                         input logic [1:0] w, input logic [63:0] a, input logic [63:0] sd,
                         input logic [63:0] rd, input logic e, input int wt);
        int          xl, nl, sz, off;
        logic [63:0] lim, v;
        logic        m;
        req_t        r;
        cmp_t        c;
        wait_ready(d);
        xl  = (d == 0) ? 32 : 64;
        nl  = xl / 8;
        sz  = 1 << w;
        lim = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        m   = ((w == 2'd3) && (xl == 32)) || ((a % 64'(sz)) != 0);
        off = int'(a % 64'(nl));
        r.addr = a & lim; r.wr = s && !l; r.strb = '0; r.wdata = '0;
        r.rdata = rd; r.err = e; r.wait_n = wt; r.late = late_next;
        for (int i = 0; i < nl; i++) begin
            r.strb[i] = (i >= off) && (i < off + sz);
            r.wdata[i*8 +: 8] = sd[(i % sz)*8 +: 8];
        end
        v = '0;
        for (int b = 0; b < sz && b < 8; b++) v[b*8 +: 8] = rd[((off + b) % 8)*8 +: 8];
        if (!u && (sz * 8 < xl) && v[sz*8-1]) v = v | ~((64'd1 << (sz * 8)) - 64'd1);
        v = v & lim;
        if (r.wr || e || m) v = '0;
        c.ldata = v; c.mis = m; c.berr = m ? 1'b0 : e;
        c.cyc = cyc + 1 + (m ? 0 : 2 + wt);
        if (!m) rq.push_back(r);
        sbq.push_back(c);
        valid[d] = 1'b1; ld[d] = l; st[d] = s; uns[d] = u; wid[d] = w;
        addr[d] = a; sdata[d] = sd;
        @(negedge clk);
        valid[d] = 1'b0; ld[d] = 1'b0; st[d] = 1'b0;
        addr[d] = 64'($urandom); sdata[d] = 64'($urandom);
    endtask

    task automatic rand_ops(input int d, input int n);
        logic        l, u, e;
        logic [1:0]  w;
        logic [63:0] a;
        for (int i = 0; i < n; i++) begin
            l = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            e = ($urandom_range(0, 7) == 0);
            w = 2'($urandom_range(0, 3));
            a = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~(64'(1 << w) - 64'd1);
            issue(d, l, !l, u, w, a, {$urandom, $urandom}, {$urandom, $urandom}, e,
                  int'($urandom_range(0, 2)));
            wait_idle(d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic got_rsp;
        for (int d = 0; d < 2; d++) begin
            valid[d] = 1'b0; ld[d] = 1'b0; st[d] = 1'b0; uns[d] = 1'b0;
            wid[d] = 2'b00; addr[d] = '0; sdata[d] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 64'(rdy[d]), 64'd1);
            chk("rst_busy", 64'(busy[d]), 64'd0);
            chk("rst_reqv", 64'(mreqv[d]), 64'd0);
            chk("rst_done", 64'(dn[d]), 64'd0);
            chk("rst_ldata", ldata[d], 64'd0);
            chk("rst_strb", 64'(mstrb[d]), 64'd0);
        end
        rst_n = 1'b1;

        // 32-bit unit: byte store to lane 3, accepted on the first edge after reset
        issue(0, 1'b0, 1'b1, 1'b0, 2'd0, 64'h1003, 64'hAB, 64'h0, 1'b0, 0);
        wait_idle(0);
        // signed / unsigned halfword loads from the upper half
        issue(0, 1'b1, 1'b0, 1'b0, 2'd1, 64'h2002, 64'h0, 64'h8001_1234, 1'b0, 0);
        wait_idle(0);
        repeat (3) @(negedge clk);
        chk("lh_signed_hold", ldata[0], 64'hFFFF_8001);
        issue(0, 1'b1, 1'b0, 1'b1, 2'd1, 64'h2002, 64'h0, 64'h8001_1234, 1'b0, 0);
        wait_idle(0);
        chk("lh_unsigned", ldata[0], 64'h0000_8001);
        // misaligned word and doubleword on the 32-bit unit
        issue(0, 1'b1, 1'b0, 1'b0, 2'd2, 64'h1001, 64'h0, 64'hDEAD_BEEF, 1'b0, 0);
        wait_idle(0);
        chk("lw_misaligned", 64'(mis[0]), 64'd1);
        issue(0, 1'b1, 1'b0, 1'b0, 2'd3, 64'h10, 64'h0, 64'hDEAD_BEEF, 1'b0, 0);
        wait_idle(0);
        chk("ld32_misaligned", 64'(mis[0]), 64'd1);
        // three ready wait cycles then an error response
        issue(0, 1'b1, 1'b0, 1'b0, 2'd2, 64'h3000, 64'h0, 64'h1234_5678, 1'b1, 3);
        wait_idle(0);
        chk("err_berr", 64'(berr[0]), 64'd1);
        chk("err_ldata", ldata[0], 64'd0);
        // valid with neither load nor store is ignored
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        chk("ignore_busy", 64'(busy[0]), 64'd0);
        chk("ignore_reqv", 64'(mreqv[0]), 64'd0);
        // load and store both set behaves as a load
        issue(0, 1'b1, 1'b1, 1'b0, 2'd0, 64'h2001, 64'h55, 64'h0000_7F00, 1'b0, 1);
        wait_idle(0);
        issue(0, 1'b0, 1'b1, 1'b0, 2'd1, 64'h0402, 64'hC3D2, 64'h0, 1'b0, 0);
        wait_idle(0);
        rand_ops(0, 20);

        // reset while waiting for the response: no completion afterwards
        late_next = 1'b1;
        issue(0, 1'b1, 1'b0, 1'b0, 2'd2, 64'h40, 64'h0, 64'h1234_5678, 1'b0, 0);
        late_next = 1'b0;
        got_rsp = 1'b0;
        for (int k = 0; k < 20 && !got_rsp; k++) begin
            @(negedge clk);
            if (busy[0] && !mreqv[0]) got_rsp = 1'b1;
        end
        chk("reach_rsp", 64'(got_rsp), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 64'(rdy[0]), 64'd1);
        chk("async_rst_busy", 64'(busy[0]), 64'd0);
        chk("async_rst_reqv", 64'(mreqv[0]), 64'd0);
        sbq.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("late_rsp_busy", 64'(busy[0]), 64'd0);
        chk("late_rsp_ldata", ldata[0], 64'd0);
        issue(0, 1'b1, 1'b0, 1'b1, 2'd0, 64'h7, 64'h0, 64'h9A00_0000, 1'b0, 0);
        wait_idle(0);

        // 64-bit unit
        issue(1, 1'b1, 1'b0, 1'b0, 2'd2, 64'h4, 64'h0, 64'h8000_0000_0000_0000, 1'b0, 0);
        wait_idle(1);
        chk("lw64_signed", ldata[1], 64'hFFFF_FFFF_8000_0000);
        issue(1, 1'b1, 1'b0, 1'b0, 2'd3, 64'h8, 64'h0, 64'h8000_0000_0000_0000, 1'b0, 0);
        wait_idle(1);
        chk("ld64_full", ldata[1], 64'h8000_0000_0000_0000);
        issue(1, 1'b1, 1'b0, 1'b1, 2'd2, 64'h4, 64'h0, 64'h8000_0000_0000_0000, 1'b0, 2);
        wait_idle(1);
        issue(1, 1'b0, 1'b1, 1'b0, 2'd0, 64'h5, 64'h3C, 64'h0, 1'b0, 0);
        wait_idle(1);
        issue(1, 1'b0, 1'b1, 1'b0, 2'd2, 64'h4, 64'hFEDC_BA98, 64'h0, 1'b0, 1);
        wait_idle(1);
        issue(1, 1'b1, 1'b0, 1'b0, 2'd3, 64'hC, 64'h0, 64'h1, 1'b0, 0);
        wait_idle(1);
        rand_ops(1, 20);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 Parameter STRB_W, default XLEN/8, byte-lane count; derived, not overridden.
REQ-003 i_Clk_1  in  1  single clock, all state on rising edge.
REQ-004 i_Rstn_1  in  1  reset, asynchronous, active-low.
REQ-005 i_Valid_1  in  1  core request valid.
REQ-006 o_Ready_1  out  1  LSU can accept a request.
REQ-007 i_Load_1 / i_Store_1 / i_LoadUnsigned_1  in  1 each  operation type, zero-extend select.
REQ-008 i_LoadStoreWidth_2  in  2  00 byte, 01 half, 10 word, 11 double.
REQ-009 i_Addr_XLEN / i_StoreData_XLEN  in  XLEN  byte address, store data (LSBs used).
REQ-010 o_MemReqValid_1 out 1, i_MemReqReady_1 in 1  memory request handshake.
REQ-011 o_MemAddr_XLEN out XLEN, o_MemWrite_1 out 1, o_MemWData_XLEN out XLEN, o_MemStrb out STRB_W  request payload.
REQ-012 i_MemRspValid_1 in 1, i_MemRData_XLEN in XLEN, i_MemRspErr_1 in 1  memory response (one per request, loads and stores).
REQ-013 o_Done_1 out 1, o_LoadData_XLEN out XLEN, o_Misaligned_1 out 1, o_BusErr_1 out 1, o_Busy_1 out 1  completion.

Function
REQ-014 States IDLE, REQ, RSP, DONE; o_Ready_1=1 only in IDLE; o_Busy_1 = not IDLE.
REQ-015 Accept when i_Valid_1 & o_Ready_1 & (i_Load_1 | i_Store_1); all inputs latched at accept; neither set -> ignored, stay IDLE; both set -> treated as load.
REQ-016 Size = 1<<width bytes; width 11 with XLEN=32, or addr not a multiple of size, is misaligned.
REQ-017 Misaligned accept: IDLE->DONE, no memory request, o_Misaligned_1=1 in DONE, o_LoadData_XLEN=0.
REQ-018 Aligned accept: IDLE->REQ; o_MemReqValid_1=1 with payload held stable until i_MemReqReady_1; then REQ->RSP.
REQ-019 o_MemAddr_XLEN = latched address unmodified; o_MemWrite_1 = store.
REQ-020 o_MemStrb: size contiguous ones starting at lane addr[log2(STRB_W)-1:0], same for loads and stores.
REQ-021 o_MemWData_XLEN: store datum of size bytes replicated across all lanes (byte x STRB_W, half x STRB_W/2, ...); no read-modify-write.
REQ-022 i_MemRspValid_1 sampled only in RSP; ignored in all other states; RSP->DONE on it.
REQ-023 Load extract: lane at addr offset, size bytes, sign-extended from top bit unless i_LoadUnsigned_1; word on XLEN=64 also extends; store completion gives o_LoadData_XLEN=0.
REQ-024 i_MemRspErr_1 with response: o_BusErr_1=1, o_LoadData_XLEN=0.
REQ-025 DONE lasts exactly one cycle: o_Done_1=1, flags valid; then ->IDLE; o_LoadData_XLEN and flags hold until next DONE.
REQ-026 Latency with zero-wait memory: accept edge T0, REQ T1, RSP T2, Done T3; each memory wait cycle adds one; next accept possible T4.

Reset
REQ-027 i_Rstn_1 low immediately forces IDLE and all outputs 0 except o_Ready_1=1, including mid-REQ/RSP (pending request dropped, late response ignored).
REQ-028 After release, first accept possible on first rising edge with i_Rstn_1 high.

Verification
REQ-029 XLEN=32, SB addr 0x1003 data 0xAB, zero-wait -> Strb 1000, WData 0xABABABAB, Done at T3.
REQ-030 XLEN=32, LH addr 0x2002, RData 0x8001_1234, signed -> 0xFFFF8001; unsigned -> 0x00008001.
REQ-031 XLEN=64, LW addr 0x4, RData 0x80000000_00000000, signed -> 0xFFFFFFFF80000000; LD addr 0x8 -> full RData.
REQ-032 LW addr 0x1001 -> no MemReqValid, Done at T1 equivalent (next cycle after accept), Misaligned=1; XLEN=32 width 11 -> Misaligned=1.
REQ-033 MemReqReady held low 3 cycles, payload stable, then RspErr=1 -> BusErr=1, LoadData=0, Done at T6.
REQ-034 Reset asserted in RSP -> MemReqValid=0, Ready=1 asynchronously; response pulse after release causes no Done.
